// File: rtl/fmdll_pkg.sv
// Shared FMDLL types and constants: controller state encoding and delay-code geometry.
package fmdll_pkg;
    localparam int FMDLL_CODE_W = 10;
    localparam logic [FMDLL_CODE_W-1:0] CODE_MID = {1'b1, {(FMDLL_CODE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SAR, TRACK} state_e;
endpackage

// File: rtl/dll_lock_ctrl_if.sv
// Control/observe bundle between the phase-detector side and the DLL delay-code controller.
interface dll_lock_ctrl_if #(parameter int CODE_W = fmdll_pkg::FMDLL_CODE_W);
    logic              en;
    logic              pd_late;
    logic [CODE_W-1:0] code;
    logic              code_upd;
    logic              locked;
    logic              railed;

    modport master (output en, pd_late, input code, code_upd, locked, railed);
    modport slave  (input en, pd_late, output code, code_upd, locked, railed);
endinterface

// File: rtl/dll_track_filter.sv
// Tracking vote filter: signed up/down accumulator that emits a single inc/dec pulse
// when the vote balance reaches +/-FILT_TH, then restarts from zero.
module dll_track_filter #(
    parameter int FILT_TH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vote,
    input  logic late,
    input  logic clr,
    output logic inc,
    output logic dec
);
    localparam int ACC_W = $clog2(FILT_TH) + 2;
    localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_nx;

    always_comb begin
        acc_nx = late ? acc_q - 1'b1 : acc_q + 1'b1;
        inc    = vote && !clr && (acc_nx == TH_POS);
        dec    = vote && !clr && (acc_nx == TH_NEG);
        acc_d  = acc_q;
        if (clr || inc || dec) acc_d = '0;
        else if (vote)         acc_d = acc_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL delay-code controller: SAR coarse acquisition from midscale, then filtered +/-1
// tracking with an alternating-step lock detector and sticky end-of-range flag.
module dll_lock_ctrl
    import fmdll_pkg::*;
#(
    parameter int CODE_W  = FMDLL_CODE_W,
    parameter int SETTLE  = 4,
    parameter int FILT_TH = 4,
    parameter int LOCK_N  = 8
) (
    input logic            CLK_exit,
    input logic            rst_n,
    dll_lock_ctrl_if.slave bus
);
    localparam int TMR_W = $clog2(SETTLE);
    localparam int IDX_W = $clog2(CODE_W);
    localparam int LCK_W = $clog2(LOCK_N + 1);
    localparam logic [CODE_W-1:0] MID     = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] MAXC    = '1;
    localparam logic [TMR_W-1:0]  TMR_LD  = TMR_W'(SETTLE - 1);
    localparam logic [LCK_W-1:0]  LCK_MAX = LCK_W'(LOCK_N);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_upd_q, code_upd_d;
    logic              locked_q, locked_d;
    logic              railed_q, railed_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              dir_vld_q, dir_vld_d;
    logic              dir_up_q, dir_up_d;
    logic [LCK_W-1:0]  lcnt_q, lcnt_d;
    logic              sample, vote, filt_clr, inc, dec, rail;

    // PD is only trusted on the last cycle of each settle window.
    assign sample   = (tmr_q == '0);
    assign vote     = bus.en && (state_q == TRACK) && sample;
    assign filt_clr = !bus.en || (state_q != TRACK);

    dll_track_filter #(.FILT_TH(FILT_TH)) u_filt (
        .clk   (CLK_exit),
        .rst_n (rst_n),
        .vote  (vote),
        .late  (bus.pd_late),
        .clr   (filt_clr),
        .inc   (inc),
        .dec   (dec)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        locked_d  = locked_q;
        railed_d  = railed_q;
        tmr_d     = sample ? TMR_LD : tmr_q - 1'b1;
        idx_d     = idx_q;
        dir_vld_d = dir_vld_q;
        dir_up_d  = dir_up_q;
        lcnt_d    = lcnt_q;
        rail      = 1'b0;
        if (!bus.en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            railed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SAR;
                    code_d  = MID;
                    idx_d   = IDX_W'(CODE_W - 1);
                    tmr_d   = TMR_LD;
                end
                SAR: if (sample) begin
                    if (bus.pd_late) code_d[idx_q] = 1'b0;
                    if (idx_q != '0) begin
                        code_d[idx_q - 1'b1] = 1'b1;
                        idx_d = idx_q - 1'b1;
                    end else begin
                        state_d   = TRACK;
                        dir_vld_d = 1'b0;
                        lcnt_d    = '0;
                    end
                end
                TRACK: if (inc || dec) begin
                    rail = inc ? (code_q == MAXC) : (code_q == '0);
                    if (rail) railed_d = 1'b1;
                    else      code_d   = inc ? code_q + 1'b1 : code_q - 1'b1;
                    // A railed step never counts as an alternation.
                    if (dir_vld_q && (dir_up_q != inc) && !rail) begin
                        lcnt_d   = (lcnt_q == LCK_MAX) ? lcnt_q : lcnt_q + 1'b1;
                        locked_d = (lcnt_d == LCK_MAX);
                    end else begin
                        lcnt_d   = '0;
                        locked_d = 1'b0;
                    end
                    dir_vld_d = 1'b1;
                    dir_up_d  = inc;
                end
                default: state_d = IDLE;
            endcase
        end
        code_upd_d = (code_d != code_q);
    end

    always_ff @(posedge CLK_exit or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= MID;
            code_upd_q <= 1'b0;
            locked_q   <= 1'b0;
            railed_q   <= 1'b0;
            tmr_q      <= '0;
            idx_q      <= IDX_W'(CODE_W - 1);
            dir_vld_q  <= 1'b0;
            dir_up_q   <= 1'b0;
            lcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            code_upd_q <= code_upd_d;
            locked_q   <= locked_d;
            railed_q   <= railed_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            dir_vld_q  <= dir_vld_d;
            dir_up_q   <= dir_up_d;
            lcnt_q     <= lcnt_d;
        end
    end

    assign bus.code     = code_q;
    assign bus.code_upd = code_upd_q;
    assign bus.locked   = locked_q;
    assign bus.railed   = railed_q;
endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl: behavioural PD around a target code, SAR code
// expectations queued at each decision and popped when the new code appears.
module tb_dll_lock_ctrl;
    import fmdll_pkg::*;

    logic CLK_exit = 1'b0;
    logic rst_n;
    always #5 CLK_exit = ~CLK_exit;

    dll_lock_ctrl_if bus ();
    dll_lock_ctrl dut (.CLK_exit(CLK_exit), .rst_n(rst_n), .bus(bus));

    int         nvec = 0;
    int         nerr = 0;
    int         j;
    int         target;
    logic [9:0] exp_code;
    logic [9:0] exp_q[$];
    bit         seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h (j=%0d)", tag, obs, exp, j);
        end
    endtask

    task automatic tick();
        @(posedge CLK_exit);
        @(negedge CLK_exit);
        j++;
    endtask

    task automatic reset_pulse();
        @(negedge CLK_exit);
        bus.en = 1'b0;
        rst_n  = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Runs SAR from en assertion through observation point last_j, checking every cycle.
    task automatic sar_run(input int tgt, input logic [9:0] prev, input int last_j);
        logic [9:0] prv, nxt;
        int b, fin;
        @(negedge CLK_exit);
        target   = tgt;
        exp_q.delete();
        exp_code = CODE_MID;
        prv      = prev;
        j        = 0;
        bus.en   = 1'b1;
        bus.pd_late = (int'(bus.code) > target);
        tick();
        while (j <= last_j) begin
            if (j % 4 == 1 && j > 1) exp_code = exp_q.pop_front();
            chk("sar_code", 32'(bus.code), 32'(exp_code));
            chk("sar_upd", 32'(bus.code_upd), 32'(exp_code != prv));
            chk("sar_lock", 32'(bus.locked), 32'(0));
            prv = exp_code;
            bus.pd_late = (int'(bus.code) > target);
            if (j % 4 == 0) begin
                b   = 10 - j / 4;
                nxt = exp_code;
                if (bus.pd_late) nxt[b] = 1'b0;
                if (b > 0) nxt[b-1] = 1'b1;
                exp_q.push_back(nxt);
            end
            tick();
        end
        if (last_j >= 41) begin
            fin = (tgt < 0) ? 0 : ((tgt > 1023) ? 1023 : tgt);
            chk("sar_final", 32'(bus.code), 32'(fin));
        end
    endtask

    // Code must stay put in TRACK; railed expected from observation rail_from on.
    task automatic hold_run(input logic [9:0] c, input int rail_from, input int last_j, input bit noisy);
        while (j <= last_j) begin
            chk("hold_code", 32'(bus.code), 32'(c));
            chk("hold_upd", 32'(bus.code_upd), 32'(0));
            chk("hold_lock", 32'(bus.locked), 32'(0));
            chk("hold_rail", 32'(bus.railed), 32'(j >= rail_from));
            if (noisy) bus.pd_late = (j < 44) ? 1'b1 : ((((j - 44) / 12) % 2) == 1);
            else       bus.pd_late = (int'(bus.code) > target);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        j = 0;
        rst_n = 1'b1;
        bus.en = 1'b0;
        bus.pd_late = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_code", 32'(bus.code), 32'(10'h200));
        chk("rst_upd", 32'(bus.code_upd), 32'(0));
        chk("rst_lock", 32'(bus.locked), 32'(0));
        chk("rst_rail", 32'(bus.railed), 32'(0));
        #2 rst_n = 1'b1;

        // Acquire 0x15A, then track it until lock.
        sar_run(32'h15A, CODE_MID, 41);
        while (j <= 190) begin
            int n;
            n = (j - 41) / 16;
            chk("trk_code", 32'(bus.code), (n % 2 == 1) ? 32'h15B : 32'h15A);
            chk("trk_upd", 32'(bus.code_upd), 32'((j - 41) % 16 == 0));
            chk("trk_lock", 32'(bus.locked), 32'(n >= 9));
            bus.pd_late = (int'(bus.code) > target);
            tick();
        end

        // Move the target: lock must drop, then reacquire around 0x160.
        target = 32'h160;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            bus.pd_late = (int'(bus.code) > target);
            tick();
            if (!bus.locked) seen = 1'b1;
        end
        chk("unlock", 32'(seen), 32'(1));
        for (int k = 0; k < 600 && !bus.locked; k++) begin
            bus.pd_late = (int'(bus.code) > target);
            tick();
        end
        chk("relock", 32'(bus.locked), 32'(1));
        chk("relock_code", 32'(bus.code == 10'h160 || bus.code == 10'h161), 32'(1));

        // Asynchronous reset while locked.
        #2 bus.en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_code", 32'(bus.code), 32'(10'h200));
        chk("arst_lock", 32'(bus.locked), 32'(0));
        chk("arst_upd", 32'(bus.code_upd), 32'(0));
        chk("arst_rail", 32'(bus.railed), 32'(0));
        #1 rst_n = 1'b1;

        // Target beyond full scale: rail high.
        reset_pulse();
        sar_run(32'h7FF, CODE_MID, 41);
        hold_run(10'h3FF, 57, 80, 1'b0);
        bus.en = 1'b0;
        tick();
        chk("drop_rail", 32'(bus.railed), 32'(0));
        chk("drop_code", 32'(bus.code), 32'(10'h3FF));

        // PD always late: rail low.
        reset_pulse();
        sar_run(-1, CODE_MID, 41);
        hold_run(10'h000, 57, 80, 1'b0);

        // Noisy 3-up/3-down votes never reach threshold.
        reset_pulse();
        sar_run(32'h15A, CODE_MID, 41);
        hold_run(10'h15A, 1000, 200, 1'b1);

        // Drop en with idx=5, hold, then restart from midscale.
        reset_pulse();
        sar_run(32'h15A, CODE_MID, 17);
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_code", 32'(bus.code), 32'(10'h160));
            chk("idle_upd", 32'(bus.code_upd), 32'(0));
            chk("idle_lock", 32'(bus.locked), 32'(0));
        end
        sar_run(32'h15A, 10'h160, 41);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
